mmc3_a12_scanline_irq: RTL
==========================

// Module: mmc3_a12_scanline_irq
// PURPOSE
// - Scanline IRQ stage for the MMC3-family mappers (049 and kin): filters PPU A12, derives one counter clock per scanline, runs the reload/decrement/IRQ logic.
// - Sits between the PPU bus and the mapper's irq output; the mapper core decodes $C000-$E001 writes and forwards them here.
// - Replaces per-mapper shift-register A12 detection with one verified, save-state-capable block.
// PARAMETERS
// - A12_LOW_MIN  3  consecutive m2 samples of A12=0 required before a rise counts as a clock (1..7)
// - CNT_W        8  counter/latch width
// PORTS
// - m2          in   1      sole clock; all state updates on rising edge
// - map_rst     in   1      reset, asynchronous, active-high
// - ppu_a12     in   1      PPU address bit 12, raw
// - irq_rev_a   in   1      1 = Rev A/NEC IRQ rule, 0 = Rev B/Sharp rule; static per game
// - reg_we      in   1      one-cycle write strobe for IRQ register
// - reg_sel     in   2      0=$C000 latch, 1=$C001 reload, 2=$E000 disable/ack, 3=$E001 enable
// - reg_dat     in   8      write data
// - ss_we       in   1      save-state write strobe
// - ss_addr     in   2      save-state index
// - ss_wdat     in   8      save-state write data
// - ss_rdat     out  8      save-state read data, combinational
// - irq_out     out  1      IRQ request, active-high, registered
// BEHAVIOUR
// - Reset: a12_q=0, low_cnt=0, latch=0, cnt=0, reload_pend=0, irq_en=0, irq_flag=0; irq_out=0.
// - Filter: each edge a12_q<=ppu_a12. If ppu_a12=0, low_cnt<=min(low_cnt+1,7) (saturates); else low_cnt<=0.
// - clk_evt = ppu_a12 & !a12_q & (low_cnt>=A12_LOW_MIN); single-cycle, combinational into counter logic.
// - Rise after fewer than A12_LOW_MIN low samples: ignored, low_cnt still cleared.
// - Counter on clk_evt: if reload_pend | cnt==0 -> cnt<=latch, reload_pend<=0; else cnt<=cnt-1.
// - Next value nxt = that assigned value. Set irq_flag when irq_en & nxt==0 and:
// - Rev B: always (latch=0 fires every scanline).
// - Rev A: only if old cnt!=0 or reload_pend was 1 (counter sitting at 0 with latch 0 fires once).
// - Registers: sel0 latch<=reg_dat; sel1 cnt<=0, reload_pend<=1; sel2 irq_en<=0, irq_flag<=0; sel3 irq_en<=1.
// - Simultaneous write+clk_evt: counter step uses pre-write latch/reload_pend/irq_en; then write applies.
// - sel1 same cycle: cnt ends 0, reload_pend ends 1. sel2 same cycle as set: clear wins.
// - irq_out = irq_flag (1 m2 after clk_evt edge); stays high until sel2 or reset.
// - Save state (ss_we priority over all other updates that cycle):
// - 0 latch; 1 cnt; 2 {3'b0,low_cnt[2:0],a12_q,irq_rev-independent 0}; 3 {5'b0,reload_pend,irq_en,irq_flag}.
// - ss_rdat returns same layout; unused bits read 0.
// - map_rst mid-frame: everything to reset values asynchronously; first clock after release needs full A12_LOW_MIN low samples.
// STRUCTURE
// - Package mmc3_irq_pkg: REG_LATCH/REG_RELOAD/REG_DISABLE/REG_ENABLE codes, SS_* indices, CNT_W default.
// - Sub-module a12_edge_filter (a12_q, low_cnt, clk_evt); counter/flags/ss mux in this module.
// TESTING
// - A12 low 4 cycles then high, latch=3, after sel1 -> clk_evt each rise; irq_out rises 1 m2 after 4th clk_evt.
// - A12 glitch low 2 cycles then high (A12_LOW_MIN=3) -> no clk_evt, cnt unchanged.
// - latch=0, irq_rev_a=0, enabled -> irq every clk_evt after ack; irq_rev_a=1 -> single irq after reload, none after.
// - sel2 and irq-setting clk_evt in same m2 -> irq_out stays 0, irq_en=0.
// - sel1 same cycle as clk_evt with cnt=5 -> cnt=0, reload_pend=1; next clk_evt loads latch.
// - ss write cnt=0x42, flags=3'b011, then read back -> ss_rdat 0x42/0x03; irq_out=1; map_rst pulse -> all zero.

Source files
------------

// File: rtl/mmc3_irq_pkg.sv
// Shared constants and types for the MMC3-family scanline IRQ block.
package mmc3_irq_pkg;

  localparam int unsigned CNT_W_DEF       = 8;
  localparam int unsigned A12_LOW_MIN_DEF = 3;
  localparam int unsigned LOW_CNT_W       = 3;
  localparam logic [LOW_CNT_W-1:0] LOW_CNT_MAX = '1;

  typedef enum logic [1:0] {
    REG_LATCH   = 2'd0,
    REG_RELOAD  = 2'd1,
    REG_DISABLE = 2'd2,
    REG_ENABLE  = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    SS_LATCH = 2'd0,
    SS_CNT   = 2'd1,
    SS_FILT  = 2'd2,
    SS_FLAGS = 2'd3
  } ss_idx_e;

  // Bit order matches the save-state flags byte {reload_pend, irq_en, irq_flag}.
  typedef struct packed {
    logic reload_pend;
    logic irq_en;
    logic irq_flag;
  } irq_flags_t;

endpackage

// File: rtl/mmc3_a12_scanline_irq_a12_edge_filter.sv
// PPU A12 low-time filter: a rise only clocks the counter after enough low m2 samples.
module a12_edge_filter
  import mmc3_irq_pkg::*;
#(
  parameter int unsigned A12_LOW_MIN = A12_LOW_MIN_DEF
) (
  input  logic                 m2,
  input  logic                 map_rst,
  input  logic                 ppu_a12,
  input  logic                 ss_ld,
  input  logic [LOW_CNT_W-1:0] ss_low_cnt,
  input  logic                 ss_a12,
  output logic                 clk_evt_c,
  output logic                 a12_q,
  output logic [LOW_CNT_W-1:0] low_cnt_q
);

  logic                 a12_d;
  logic [LOW_CNT_W-1:0] low_cnt_d;

  assign clk_evt_c = ppu_a12 && !a12_q && (low_cnt_q >= LOW_CNT_W'(A12_LOW_MIN));

  // Saturating low-sample counter; any high sample clears it.
  always_comb begin
    a12_d     = ppu_a12;
    low_cnt_d = '0;
    if (!ppu_a12) begin
      low_cnt_d = (low_cnt_q == LOW_CNT_MAX) ? low_cnt_q : low_cnt_q + LOW_CNT_W'(1);
    end
    if (ss_ld) begin
      a12_d     = ss_a12;
      low_cnt_d = ss_low_cnt;
    end
  end

  always_ff @(posedge m2 or posedge map_rst) begin
    if (map_rst) begin
      a12_q     <= 1'b0;
      low_cnt_q <= '0;
    end else begin
      a12_q     <= a12_d;
      low_cnt_q <= low_cnt_d;
    end
  end

endmodule

// File: rtl/mmc3_a12_scanline_irq.sv
// MMC3 scanline IRQ: A12-clocked reload/decrement counter with Rev A/B fire rules
// and a save-state window over all architectural state.
module mmc3_a12_scanline_irq
  import mmc3_irq_pkg::*;
#(
  parameter int unsigned A12_LOW_MIN = A12_LOW_MIN_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic       m2,
  input  logic       map_rst,
  input  logic       ppu_a12,
  input  logic       irq_rev_a,
  input  logic       reg_we,
  input  logic [1:0] reg_sel,
  input  logic [7:0] reg_dat,
  input  logic       ss_we,
  input  logic [1:0] ss_addr,
  input  logic [7:0] ss_wdat,
  output logic [7:0] ss_rdat,
  output logic       irq_out
);

  logic                 clk_evt_c;
  logic                 a12_q;
  logic [LOW_CNT_W-1:0] low_cnt_q;
  logic                 ss_filt_ld_c;

  logic [CNT_W-1:0]     latch_q, latch_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [CNT_W-1:0]     cnt_nxt_c;
  irq_flags_t           flags_q, flags_d;
  logic                 reload_c;
  logic                 fire_c;

  assign ss_filt_ld_c = ss_we && (ss_addr == SS_FILT);

  a12_edge_filter #(
    .A12_LOW_MIN (A12_LOW_MIN)
  ) u_filt (
    .m2         (m2),
    .map_rst    (map_rst),
    .ppu_a12    (ppu_a12),
    .ss_ld      (ss_filt_ld_c),
    .ss_low_cnt (ss_wdat[4:2]),
    .ss_a12     (ss_wdat[1]),
    .clk_evt_c  (clk_evt_c),
    .a12_q      (a12_q),
    .low_cnt_q  (low_cnt_q)
  );

  // Counter step uses pre-write state; Rev A suppresses the repeat fire of a parked zero.
  always_comb begin
    reload_c  = flags_q.reload_pend || (cnt_q == '0);
    cnt_nxt_c = reload_c ? latch_q : cnt_q - CNT_W'(1);
    fire_c    = clk_evt_c && flags_q.irq_en && (cnt_nxt_c == '0) &&
                (!irq_rev_a || (cnt_q != '0) || flags_q.reload_pend);
  end

  // Priority, lowest to highest: counter step, register write, save-state write.
  always_comb begin
    latch_d = latch_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;

    if (clk_evt_c) begin
      cnt_d = cnt_nxt_c;
      if (reload_c) flags_d.reload_pend = 1'b0;
    end
    if (fire_c) flags_d.irq_flag = 1'b1;

    if (reg_we) begin
      case (reg_sel)
        REG_LATCH:   latch_d = CNT_W'(reg_dat);
        REG_RELOAD: begin
          cnt_d               = '0;
          flags_d.reload_pend = 1'b1;
        end
        REG_DISABLE: begin
          flags_d.irq_en   = 1'b0;
          flags_d.irq_flag = 1'b0;
        end
        REG_ENABLE:  flags_d.irq_en = 1'b1;
        default: ;
      endcase
    end

    if (ss_we) begin
      case (ss_addr)
        SS_LATCH: latch_d = CNT_W'(ss_wdat);
        SS_CNT:   cnt_d   = CNT_W'(ss_wdat);
        SS_FLAGS: flags_d = irq_flags_t'(ss_wdat[2:0]);
        default: ;
      endcase
    end
  end

  always_ff @(posedge m2 or posedge map_rst) begin
    if (map_rst) begin
      latch_q <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      latch_q <= latch_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    ss_rdat = '0;
    case (ss_addr)
      SS_LATCH: ss_rdat = 8'(latch_q);
      SS_CNT:   ss_rdat = 8'(cnt_q);
      SS_FILT:  ss_rdat = {3'b000, low_cnt_q, a12_q, 1'b0};
      SS_FLAGS: ss_rdat = {5'b00000, flags_q};
      default: ;
    endcase
  end

  assign irq_out = flags_q.irq_flag;

endmodule
